sevenseg_scan: RTL

- Time-multiplexed driver for the Nexys 4 eight-digit common-anode 7-segment display.
- Sits directly downstream of the PicoBlaze register interface. Consumes the digit-code and decimal-point registers it writes, and drives the anode, cathode and DP pins.
- Emits a one-cycle end-of-frame pulse that can feed the interface's interrupt_request input as a periodic tick.
- Blanks all anodes between digit slots to suppress ghosting.

---
 rtl/sevenseg_scan_if.sv | 20 ++
 rtl/sevenseg_scan.sv | 92 +++++++++
 2 files changed

// File: rtl/sevenseg_scan_if.sv
// rtl/sevenseg_scan_if.sv - register-side inputs and display pins of the 7-segment scanner
interface sevenseg_scan_if;
  logic [39:0] digit_codes;
  logic [7:0]  dp_in;
  logic [7:0]  digit_en;
  logic [7:0]  anode_n;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic        frame_tick;

  modport master (
    output digit_codes, dp_in, digit_en,
    input  anode_n, seg_n, dp_n, frame_tick
  );

  modport slave (
    input  digit_codes, dp_in, digit_en,
    output anode_n, seg_n, dp_n, frame_tick
  );
endinterface

// File: rtl/sevenseg_scan.sv
// rtl/sevenseg_scan.sv - eight-digit time-multiplexed common-anode 7-segment scanner
module sevenseg_scan #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input logic            sysclk,
  input logic            sysreset,
  sevenseg_scan_if.slave bus
);
  localparam int            CW        = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

  typedef enum logic {PH_BLANK, PH_DRIVE} phase_t;

  phase_t        phase;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic [2:0]    idx;
  logic [4:0]    snap_code [8];
  logic [7:0]    snap_dp;
  logic [7:0]    snap_en;

  assign cnt_inc = cnt + CW'(1);

  function automatic logic [6:0] decode(input logic [4:0] code);
    case (code)
      5'd0:    decode = 7'h40;
      5'd1:    decode = 7'h79;
      5'd2:    decode = 7'h24;
      5'd3:    decode = 7'h30;
      5'd4:    decode = 7'h19;
      5'd5:    decode = 7'h12;
      5'd6:    decode = 7'h02;
      5'd7:    decode = 7'h78;
      5'd8:    decode = 7'h00;
      5'd9:    decode = 7'h10;
      5'd10:   decode = 7'h08;
      5'd11:   decode = 7'h03;
      5'd12:   decode = 7'h46;
      5'd13:   decode = 7'h21;
      5'd14:   decode = 7'h06;
      5'd15:   decode = 7'h0E;
      5'd17:   decode = 7'h3F;
      default: decode = 7'h7F;
    endcase
  endfunction

  // phase is kept in step with cnt so it always reflects the current slot position
  always_ff @(posedge sysclk) begin
    if (sysreset) begin
      cnt            <= '0;
      idx            <= '0;
      phase          <= PH_BLANK;
      for (int i = 0; i < 8; i++) snap_code[i] <= 5'd16;
      snap_dp        <= '0;
      snap_en        <= '0;
      bus.anode_n    <= 8'hFF;
      bus.seg_n      <= 7'h7F;
      bus.dp_n       <= 1'b1;
      bus.frame_tick <= 1'b0;
    end else begin
      // frame-start snapshot; slot 0 is still blanking here so the old snapshot is never shown
      if (cnt == '0 && idx == '0) begin
        for (int i = 0; i < 8; i++) snap_code[i] <= bus.digit_codes[5*i +: 5];
        snap_dp <= bus.dp_in;
        snap_en <= bus.digit_en;
      end

      if (phase == PH_DRIVE && snap_en[idx]) begin
        bus.anode_n <= ~(8'h01 << idx);
        bus.seg_n   <= decode(snap_code[idx]);
        bus.dp_n    <= ~snap_dp[idx];
      end else begin
        bus.anode_n <= 8'hFF;
        bus.seg_n   <= 7'h7F;
        bus.dp_n    <= 1'b1;
      end

      bus.frame_tick <= (cnt == CNT_LAST) && (idx == 3'd7);

      if (cnt == CNT_LAST) begin
        cnt   <= '0;
        idx   <= idx + 3'd1;
        phase <= PH_BLANK;
      end else begin
        cnt   <= cnt_inc;
        phase <= (cnt_inc < BLANK_END) ? PH_BLANK : PH_DRIVE;
      end
    end
  end
endmodule
